// File: rtl/rca_32bit_adder.sv
// rca_32bit_adder
//
// Registered 32-bit ripple-carry adder with a built-in self check.
// A chain of 32 one-bit full-adder cells computes a + b + c_in. A behavioural
// 33-bit sum is computed alongside it, and any disagreement between the two is
// registered as error_flag. Results have one cycle of latency.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a/b/c_in carry a valid operation this cycle
//   a, b       32-bit unsigned operands
//   c_in       carry into bit 0
//   out_valid  sum/c_out/error_flag hold a new result this cycle
//   sum        registered ripple sum
//   c_out      registered carry out of bit 31
//   error_flag registered mismatch between ripple and behavioural results

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

module rca_32bit_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic        out_valid,
    output logic [31:0] sum,
    output logic        c_out,
    output logic        error_flag
);

    logic [32:0] carry_p0;
    logic [31:0] ripple_sum_p0;
    logic [32:0] ref_full_p0;
    logic        mismatch_p0;

    // Stage p0: combinational ripple chain and behavioural reference.
    // The 32-cell carry chain is the critical path of the block.
    assign carry_p0[0] = c_in;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        rca_fa_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .c  (carry_p0[i]),
            .s  (ripple_sum_p0[i]),
            .co (carry_p0[i+1])
        );
    end

    assign ref_full_p0 = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
    assign mismatch_p0 = (ripple_sum_p0 != ref_full_p0[31:0]) ||
                         (carry_p0[32] != ref_full_p0[32]);

    // Stage p1: output registers. Data only loads on in_valid, so operand
    // values on idle cycles never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sum        <= 32'd0;
            c_out      <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum        <= ripple_sum_p0;
                c_out      <= carry_p0[32];
                error_flag <= mismatch_p0;
            end
        end
    end

endmodule

// File: tb/tb_rca_32bit_adder.sv
module tb_rca_32bit_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        out_valid;
    logic [31:0] sum;
    logic        c_out;
    logic        error_flag;

    int total;
    int passed;
    int flag_seen;

    rca_32bit_adder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .c_in       (c_in),
        .out_valid  (out_valid),
        .sum        (sum),
        .c_out      (c_out),
        .error_flag (error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus away from the active edge, then let it be sampled.
    task automatic drive(input logic r, input logic v, input logic [31:0] av,
                         input logic [31:0] bv, input logic cv);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        c_in     = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [31:0] es, input logic ec);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".sum"}, sum, es);
        check({tag, ".c_out"}, {31'd0, c_out}, {31'd0, ec});
        check({tag, ".error_flag"}, {31'd0, error_flag}, 32'd0);
    endtask

    initial begin
        logic [32:0] exp_full;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        total     = 0;
        passed    = 0;
        flag_seen = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        c_in      = 1'b0;

        // Reset for two cycles, then idle.
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.sum", sum, 32'd0);
        check("reset.c_out", {31'd0, c_out}, 32'd0);
        check("reset.error_flag", {31'd0, error_flag}, 32'd0);

        // All ones with carry in.
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        check_result("all_ones", 32'hFFFFFFFF, 1'b1);

        // Carry-out case.
        drive(1'b0, 1'b1, 32'hEFA123FF, 32'hF1293EFA, 1'b0);
        check_result("carry_out", 32'hE0CA62F9, 1'b1);

        // No-carry cases back to back.
        drive(1'b0, 1'b1, 32'h0AEF1843, 32'h0000830A, 1'b1);
        check_result("no_carry0", 32'h0AEF9B4E, 1'b0);
        drive(1'b0, 1'b1, 32'h0FF123FA, 32'h000AE24C, 1'b1);
        check_result("no_carry1", 32'h0FFC0647, 1'b0);

        // Carry rippling through all 32 bits.
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        check_result("full_ripple", 32'h00000000, 1'b1);

        // Idle cycle with junk operands: outputs hold.
        drive(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        check("idle.out_valid", {31'd0, out_valid}, 32'd0);
        check("idle.sum", sum, 32'h00000000);
        check("idle.c_out", {31'd0, c_out}, 32'd1);
        drive(1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
        check("idle2.sum", sum, 32'h00000000);
        check("idle2.c_out", {31'd0, c_out}, 32'd1);

        // Load a nonzero result, then reset alongside a valid operation.
        drive(1'b0, 1'b1, 32'h00000010, 32'h00000020, 1'b0);
        check_result("pre_reset", 32'h00000030, 1'b0);
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        check("midreset.out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset.sum", sum, 32'd0);
        check("midreset.c_out", {31'd0, c_out}, 32'd0);

        // Randomized back-to-back operations against a behavioural model.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            exp_full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            drive(1'b0, 1'b1, ra, rb, rc);
            if (error_flag !== 1'b0) flag_seen++;
            check_result("random", exp_full[31:0], exp_full[32]);
        end
        check("random.error_flag_count", flag_seen, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
